// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: opcodes, fetch FSM states and the IF/ID bundle.
package riscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        pred_taken;
  } if_id_t;

endpackage

// File: rtl/ifetch_predecode.sv
// Static predecoder: JAL always taken, B-type taken when the offset is backward.
module ifetch_predecode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        take,
  output logic [31:0] target
);

  logic [31:0] imm_j_s;
  logic [31:0] imm_b_s;

  assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // Opcode decode; imm[12] of a branch is the sign bit, so 1 means a backward target.
  always_comb begin
    take   = 1'b0;
    target = pc + 32'd4;
    case (instr[6:0])
      OP_JAL: begin
        take   = 1'b1;
        target = pc + imm_j_s;
      end
      OP_BRANCH: begin
        take   = instr[31];
        target = pc + imm_b_s;
      end
      default: begin
        take   = 1'b0;
        target = pc + 32'd4;
      end
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory, registers the IF/ID bundle.
// Static prediction is compiled in only when IFETCH_PREDICT_EN is defined.
module ifetch
  import riscv_pkg::*;
#(
  parameter int          MEMORY_TYPE = 0,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_re,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        pred_taken
);

  fetch_state_t state_r;
  logic [31:0]  fetch_pc_r;
  if_id_t       if_id_r;
  if_id_t       if_id_s;
  logic [31:0]  instr_s;
  logic         take_s;
  logic [31:0]  target_s;
  logic         predict_s;

  // A BSRAM keeps its output while re=0, so in that build the live word comes from memory.
  always_comb begin
    if (MEMORY_TYPE == 0) begin
      instr_s = if_id_r.instr;
    end else if (if_id_r.valid) begin
      instr_s = imem_data;
    end else begin
      instr_s = 32'h0000_0000;
    end
  end

`ifdef IFETCH_PREDICT_EN
  ifetch_predecode u_predecode (
    .instr  (instr_s),
    .pc     (if_id_r.pc),
    .take   (take_s),
    .target (target_s)
  );
`else
  assign take_s   = 1'b0;
  assign target_s = 32'h0000_0000;
`endif

  assign predict_s = take_s && if_id_r.valid && !stall;

  // Presented bundle: registered fields with the live word and the prediction flag.
  always_comb begin
    if_id_s            = if_id_r;
    if_id_s.instr      = instr_s;
    if_id_s.pred_taken = if_id_r.valid && take_s;
  end

  assign imem_re    = (state_r != BOOT) && (!stall || redirect);
  assign imem_addr  = fetch_pc_r[12:2];
  assign instr      = if_id_s.instr;
  assign pc         = if_id_s.pc;
  assign pc_plus4   = if_id_s.pc_plus4;
  assign valid      = if_id_s.valid;
  assign pred_taken = if_id_s.pred_taken;

  // Fetch FSM: redirect beats prediction, prediction beats stall, stall beats sequential fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= BOOT;
      fetch_pc_r         <= RESET_PC;
      if_id_r.instr      <= 32'h0000_0000;
      if_id_r.pc         <= RESET_PC;
      if_id_r.pc_plus4   <= RESET_PC + 32'd4;
      if_id_r.valid      <= 1'b0;
      if_id_r.pred_taken <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        RUN, KILL: begin
          if (redirect) begin
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            if_id_r.valid <= 1'b0;
            state_r       <= KILL;
          end else if (predict_s) begin
            fetch_pc_r    <= target_s;
            if_id_r.valid <= 1'b0;
            state_r       <= KILL;
          end else if (stall) begin
            state_r <= RUN;
          end else begin
            fetch_pc_r         <= fetch_pc_r + 32'd4;
            if_id_r.instr      <= imem_data;
            if_id_r.pc         <= fetch_pc_r;
            if_id_r.pc_plus4   <= fetch_pc_r + 32'd4;
            if_id_r.valid      <= 1'b1;
            if_id_r.pred_taken <= 1'b0;
            state_r            <= RUN;
          end
        end
        default: begin
          state_r       <= BOOT;
          if_id_r.valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
